// File: rtl/pipe_acc_round_pkg.sv
// Shared constants for the frame accumulator that follows the 18x25 multiplier.
package pipe_acc_round_pkg;
  localparam int PROD_W    = 43;
  localparam int ACC_W_DEF = 48;
  localparam int SHIFT_DEF = 18;
  localparam int OUT_W_DEF = 25;
endpackage

// File: rtl/pipe_acc_round_if.sv
// Product input and result output of the frame accumulator, grouped as one bus.
interface pipe_acc_round_if
  import pipe_acc_round_pkg::*;
#(
  parameter int OUT_W = OUT_W_DEF
);
  logic                     pipe_in;
  logic                     first;
  logic                     last;
  logic signed [PROD_W-1:0] p;
  logic                     pipe_out;
  logic signed [OUT_W-1:0]  y;
  logic                     sat;

  modport master (output pipe_in, first, last, p, input pipe_out, y, sat);
  modport slave  (input pipe_in, first, last, p, output pipe_out, y, sat);
endinterface

// File: rtl/pipe_acc_round_round_sat.sv
// Registered round-half-up add, then registered arithmetic rescale and clip to OUT_W.
module round_sat #(
  parameter int IN_W  = 48,
  parameter int SHIFT = 18,
  parameter int OUT_W = 25
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    fire_in,
  input  logic                    ovf_in,
  input  logic signed [IN_W-1:0]  acc,
  output logic                    fire_out,
  output logic signed [OUT_W-1:0] y,
  output logic                    sat
);
  // One guard bit above the accumulator so the rounding add can never wrap
  localparam logic [IN_W:0] HALF = {{IN_W{1'b0}}, 1'b1} << (SHIFT - 1);
  localparam logic signed [IN_W:0] Q_MAX = {{(IN_W+2-OUT_W){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [IN_W:0] Q_MIN = {{(IN_W+2-OUT_W){1'b1}}, {(OUT_W-1){1'b0}}};

  logic signed [IN_W:0]    rnd;
  logic                    ovf_b;
  logic                    fire_b;
  logic signed [IN_W:0]    q;
  logic signed [OUT_W-1:0] y_next;
  logic                    clip;

  always_ff @(posedge clk) begin
    if (reset) begin
      rnd    <= '0;
      ovf_b  <= 1'b0;
      fire_b <= 1'b0;
    end else begin
      fire_b <= fire_in;
      if (fire_in) begin
        rnd   <= (IN_W+1)'(acc) + HALF;
        ovf_b <= ovf_in;
      end
    end
  end

  assign q = rnd >>> SHIFT;

  always_comb begin
    y_next = q[OUT_W-1:0];
    clip   = 1'b0;
    if (q > Q_MAX) begin
      y_next = Q_MAX[OUT_W-1:0];
      clip   = 1'b1;
    end else if (q < Q_MIN) begin
      y_next = Q_MIN[OUT_W-1:0];
      clip   = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fire_out <= 1'b0;
      y        <= '0;
      sat      <= 1'b0;
    end else begin
      fire_out <= fire_b;
      if (fire_b) begin
        y   <= y_next;
        sat <= clip | ovf_b;
      end
    end
  end
endmodule

// File: rtl/pipe_acc_round.sv
// Frame accumulator for signed multiplier products; rounds, rescales and saturates each frame sum.
module pipe_acc_round
  import pipe_acc_round_pkg::*;
#(
  parameter int ACC_W = ACC_W_DEF,
  parameter int SHIFT = SHIFT_DEF,
  parameter int OUT_W = OUT_W_DEF
) (
  input logic              clk,
  input logic              reset,
  pipe_acc_round_if.slave  bus
);
  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] p_ext;
  logic signed [ACC_W-1:0] sum;
  logic                    ovf;
  logic                    ovf_now;
  logic                    fire_a;

  assign p_ext   = ACC_W'(bus.p);
  assign sum     = acc + p_ext;
  assign ovf_now = (acc[ACC_W-1] == p_ext[ACC_W-1]) && (sum[ACC_W-1] != acc[ACC_W-1]);

  // A last without a first simply continues the current sum
  always_ff @(posedge clk) begin
    if (reset) begin
      acc    <= '0;
      ovf    <= 1'b0;
      fire_a <= 1'b0;
    end else begin
      fire_a <= bus.pipe_in & bus.last;
      if (bus.pipe_in) begin
        if (bus.first) begin
          acc <= p_ext;
          ovf <= 1'b0;
        end else begin
          acc <= sum;
          ovf <= ovf | ovf_now;
        end
      end
    end
  end

  round_sat #(
    .IN_W  (ACC_W),
    .SHIFT (SHIFT),
    .OUT_W (OUT_W)
  ) u_round_sat (
    .clk      (clk),
    .reset    (reset),
    .fire_in  (fire_a),
    .ovf_in   (ovf),
    .acc      (acc),
    .fire_out (bus.pipe_out),
    .y        (bus.y),
    .sat      (bus.sat)
  );
endmodule

// File: tb/tb_pipe_acc_round.sv
// Directed bench for pipe_acc_round: expected pulses queued at drive time, checked at pipe_out.
module tb_pipe_acc_round;
  import pipe_acc_round_pkg::*;

  typedef struct {
    logic signed [24:0] y;
    logic               sat;
    int                 cyc;
  } exp_t;

  localparam logic signed [42:0] PMAX = 43'sh3FF_FFFF_FFFF;
  localparam logic signed [42:0] PMIN = 43'sh400_0000_0000;
  localparam logic signed [42:0] ONE  = 43'sd262144;

  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;
  int   n_assert = 0;
  int   n_fail = 0;
  exp_t sb[$];
  exp_t e;

  pipe_acc_round_if #(.OUT_W(25)) bus ();

  pipe_acc_round #(.ACC_W(48), .SHIFT(18), .OUT_W(25)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (bus.pipe_out === 1'b1) begin
      check("pulse_expected", 64'(sb.size() != 0), 64'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check("y", bus.y, e.y);
        check("sat", 64'(bus.sat), 64'(e.sat));
        check("latency_cyc", 64'(cyc), 64'(e.cyc));
      end
    end
  end

  task automatic step(input logic f, input logic l, input logic signed [42:0] pv,
                      input logic signed [24:0] ey, input logic es);
    @(posedge clk);
    #1;
    bus.pipe_in = 1'b1;
    bus.first   = f;
    bus.last    = l;
    bus.p       = pv;
    if (l) sb.push_back('{ey, es, cyc + 3});
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      bus.pipe_in = 1'b0;
      bus.first   = 1'b0;
      bus.last    = 1'b0;
      bus.p       = '0;
    end
  endtask

  initial begin
    reset       = 1'b1;
    bus.pipe_in = 1'b0;
    bus.first   = 1'b0;
    bus.last    = 1'b0;
    bus.p       = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_pipe_out", 64'(bus.pipe_out), 64'd0);
    check("rst_y", bus.y, 64'sd0);
    check("rst_sat", 64'(bus.sat), 64'd0);
    @(posedge clk);
    #1 reset = 1'b0;

    // single term, latency
    step(1, 1, 43'sd3 <<< 18, 25'sd3, 1'b0);
    idle(5);

    // rounding half-up
    step(1, 1, 43'sd1441792, 25'sd6, 1'b0);
    step(1, 1, -43'sd1441792, -25'sd5, 1'b0);
    step(1, 1, 43'sd1441791, 25'sd5, 1'b0);
    idle(5);

    // gaps inside a frame
    step(1, 0, ONE, 25'sd0, 1'b0);
    idle(1);
    step(0, 0, ONE, 25'sd0, 1'b0);
    idle(2);
    step(0, 0, ONE, 25'sd0, 1'b0);
    idle(1);
    step(0, 1, ONE, 25'sd4, 1'b0);
    idle(5);

    // clipping at both ends; exactly -2^24 is representable
    step(1, 1, PMAX, 25'sd16777215, 1'b1);
    step(1, 1, PMIN, -25'sd16777216, 1'b0);
    step(1, 0, PMIN, 25'sd0, 1'b0);
    step(0, 1, PMIN, -25'sd16777216, 1'b1);
    idle(5);

    // large frame clips, then ovf-only frame wrapping to -64, then fresh frame
    for (int i = 0; i < 32; i++) step(i == 0, i == 31, PMAX, 25'sd16777215, 1'b1);
    step(1, 1, ONE, 25'sd1, 1'b0);
    for (int i = 0; i < 64; i++) step(i == 0, i == 63, PMAX, 25'sd0, 1'b1);
    step(1, 1, ONE, 25'sd1, 1'b0);
    idle(5);

    // reset with a frame open and its last in flight: no pulse, outputs cleared
    step(1, 0, 43'sd9 <<< 18, 25'sd0, 1'b0);
    @(posedge clk);
    #1;
    bus.last    = 1'b1;
    bus.first   = 1'b0;
    bus.p       = ONE;
    @(posedge clk);
    #1;
    reset       = 1'b1;
    bus.pipe_in = 1'b0;
    bus.last    = 1'b0;
    @(posedge clk);
    #1 reset = 1'b0;
    idle(4);
    @(negedge clk);
    check("post_rst_y", bus.y, 64'sd0);
    check("post_rst_sat", 64'(bus.sat), 64'd0);

    // last with no first sums onto the cleared accumulator
    step(0, 1, 43'sd2 <<< 18, 25'sd2, 1'b0);
    idle(5);

    // back-to-back one-term frames
    step(1, 1, ONE, 25'sd1, 1'b0);
    step(1, 1, 43'sd2 <<< 18, 25'sd2, 1'b0);
    step(1, 1, 43'sd3 <<< 18, 25'sd3, 1'b0);
    idle(6);

    @(negedge clk);
    check("queue_drained", 64'(sb.size()), 64'd0);
    check("final_y", bus.y, 64'sd3);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
